// File: rtl/twos_comp_serial.sv
// twos_comp_serial: serial signed-number converter (negate, abs, SM->2C, 2C->SM), CHUNK bits per cycle, LSB first
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data/in_mode operand side;
// out_valid/out_ready/out_data/out_ovf/out_zero result side (results held until accepted)
module twos_comp_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] op_q, res_q, out_data_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       mode_q;
    logic             carry_q, neg_q, ovf_pre_q, out_valid_q, out_ovf_q, out_zero_q;
    logic             accept;
    logic [WIDTH-1:0] op_d, res_d, commit_d;
    logic             neg_d, ovf_d;
    logic [CHUNK-1:0] c, r;
    logic [CHUNK:0]   sum;
    always_comb begin
        in_ready = state_q == IDLE || (state_q == DONE && out_ready);
        accept   = in_valid && in_ready;
        op_d     = in_mode == 2'b10 ? {1'b0, in_data[WIDTH-2:0]} : in_data;
        neg_d    = in_mode == 2'b00 ? 1'b1 : in_data[WIDTH-1];
        ovf_d    = in_data == MIN && in_mode != 2'b10;
        c        = op_q[CHUNK-1:0];
        sum      = {1'b0, ~c} + {{CHUNK{1'b0}}, carry_q};
        r        = neg_q ? sum[CHUNK-1:0] : c;
        // result fills from the MSB end so the first (LSB) chunk lands at bit 0 after NCH shifts
        res_d    = (WIDTH'(r) << (WIDTH - CHUNK)) | (res_q >> CHUNK);
        // 2C->SM of a negative value: magnitude with the sign bit forced on
        commit_d = (mode_q == 2'b11 && neg_q) ? {1'b1, res_d[WIDTH-2:0]} : res_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            ovf_pre_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (accept) begin
            state_q     <= BUSY;
            op_q        <= op_d;
            mode_q      <= in_mode;
            neg_q       <= neg_d;
            ovf_pre_q   <= ovf_d;
            carry_q     <= 1'b1;
            cnt_q       <= CW'(NCH - 1);
            out_valid_q <= 1'b0;
        end else if (state_q == BUSY) begin
            op_q    <= op_q >> CHUNK;
            res_q   <= res_d;
            carry_q <= sum[CHUNK];
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_q     <= DONE;
                out_data_q  <= commit_d;
                out_ovf_q   <= ovf_pre_q;
                out_zero_q  <= commit_d == '0;
                out_valid_q <= 1'b1;
            end
        end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;
endmodule
